uvv_mko_top: RTL and testbench
==============================

# uvv_mko_top

Local-bus register slave of the UVV MKO (mil-bus channel) controller. Decodes single-word write/read cycles from the 16-bit strobe/ack local bus, holds the channel configuration registers, issues a start pulse to the channel engine and reports the five active-low channel-ready inputs. It is the top-level bus endpoint between the board's local-bus master and the MKO channel logic.

## Interface
- BASE_ADDR, 16'hA000: base of the 8-word register window (A000–A007).
- CLK_32  in  1  32 MHz system clock; all logic on rising edge.
- RESET_MKO  in  1  reset, asynchronous and active-high.
- Adr_slave_i_lbus  in  16  word address.
- Dat_slave_io_lbus  inout  16  bidirectional data; driven by slave only during read ack, else high-Z.
- We_slave_i_lbus  in  1  1 = write, 0 = read; valid while Stb high.
- Stb_slave_i_lbus  in  1  cycle request; master holds it until it sees Ack.
- Ack_slave_o_lbus  out  1  one-cycle acknowledge.
- MKO_READYD_N  in  5  per-channel ready, active low, asynchronous.
- MKO_RESET_N  out  1  channel-engine reset, = CTRL[0].
- MKO_BUS_SEL  out  1  = CTRL[15].
- MKO_DATA  out  16  TXDATA register.
- MKO_CMD  out  16  CMD register.
- MKO_SA  out  16  SUBADDR register.
- MKO_CHAN_EN  out  5  CHAN register [4:0].
- MKO_START  out  1  one-cycle pulse on every CHAN write.

## Operation
- Register map (offset from BASE_ADDR), all reset to 0:
  - 0 CTRL rw: bit0 run (0 holds channel engine in reset), bit15 bus select, bits14:1 stored and read back.
  - 1 TXDATA rw; 2 CMD rw; 3 SUBADDR rw (all 16 bits).
  - 4 CHAN rw: bits4:0 channel enable, upper bits read 0; write also pulses MKO_START.
  - 5 STATUS ro: bits4:0 = ~synchronized MKO_READYD_N, bits15:5 = 0; writes ignored.
  - 6–7 reserved: writes ignored, read 0.
- Addresses outside the window: still acked (bus never hangs), writes ignored, read 16'h0000.
- Bus FSM: IDLE -> ACK (Stb sampled high) -> WAIT_REL (always, one cycle later) -> IDLE (Stb sampled low). Exactly one access per Stb assertion, however long the master holds Stb after Ack.
- Write: data/address sampled on the IDLE->ACK edge; register updates on that same edge.
- Read: data mux registered on the IDLE->ACK edge; bus driven while Ack=1 and We=0.
- MKO_READYD_N passes through a 2-flop synchronizer before STATUS.

## Timing
- Reset: Ack=0, bus high-Z, all registers 0, MKO_RESET_N=0, MKO_START=0, FSM IDLE, synchronizer flops = 1 (not ready).
- Latency: Stb high sampled at edge N -> Ack high after edge N, low after edge N+1 (exactly one cycle).
- Write visible on register outputs after edge N; MKO_START high for the cycle after edge N.
- STATUS reflects an input change 2–3 cycles later.
- Reset asserted mid-cycle: Ack drops immediately, bus released, pending write lost; after release a still-high Stb starts a new access.
- Stb dropped before being sampled: no access, no Ack.

## Configuration
- UVV_MKO_READBACK_EN defined: offsets 0–4 read back stored values as above.
- Not defined: offsets 0–4 read 16'h0000 (write-only), only STATUS readable; write behaviour, Ack timing and outputs unchanged.

## Test plan
- Reset, then write 16'h0001 to A000 -> one-cycle Ack, MKO_RESET_N=1, MKO_BUS_SEL=0; write 16'h8001 -> MKO_BUS_SEL=1.
- Write 16'h0002 to A001, 16'h0003 to A003, A002, A004 -> MKO_DATA=2, MKO_SA=3, MKO_CMD=3, MKO_CHAN_EN=5'h03, MKO_START pulses once.
- Hold Stb high 5 cycles after Ack -> exactly one Ack, one MKO_START.
- MKO_READYD_N=5'b11111 then 5'b10110, read A005 -> 16'h0000 then 16'h0009 (after 3 cycles); bus high-Z outside Ack.
- With readback enabled, read A001 after writing 16'h8002 -> 16'h8002; without it -> 16'h0000; read 16'h1234 (out of window) -> Ack, 16'h0000.
- Assert RESET_MKO during Ack cycle -> Ack=0 at once, all registers 0, MKO_RESET_N=0.

Source files
------------

// File: rtl/uvv_mko_top.sv
// UVV MKO local-bus register slave: 8-word window at BASE_ADDR, channel config, start pulse, ready status.
// Define UVV_MKO_READBACK_EN to make offsets 0-4 readable; otherwise only STATUS reads back.
module uvv_mko_top #(
   parameter logic [15:0] BASE_ADDR = 16'hA000
) (
   input  logic        CLK_32,
   input  logic        RESET_MKO,
   input  logic [15:0] Adr_slave_i_lbus,
   inout  wire  [15:0] Dat_slave_io_lbus,
   input  logic        We_slave_i_lbus,
   input  logic        Stb_slave_i_lbus,
   output logic        Ack_slave_o_lbus,
   input  logic [4:0]  MKO_READYD_N,
   output logic        MKO_RESET_N,
   output logic        MKO_BUS_SEL,
   output logic [15:0] MKO_DATA,
   output logic [15:0] MKO_CMD,
   output logic [15:0] MKO_SA,
   output logic [4:0]  MKO_CHAN_EN,
   output logic        MKO_START
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACK      = 2'd1,
      ST_WAIT_REL = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        accept_s;
   logic        in_win_s;
   logic [2:0]  offset_s;
   logic        wr_en_s;
   logic        ack_s;
   logic        drive_s;
   logic [15:0] rd_mux_s;

   logic [15:0] ctrl_r;
   logic [15:0] txdata_r;
   logic [15:0] cmd_r;
   logic [15:0] subaddr_r;
   logic [4:0]  chan_r;
   logic        start_r;
   logic [15:0] rd_data_r;
   logic [4:0]  sync1_r;
   logic [4:0]  sync2_r;

   assign accept_s = (state_r == ST_IDLE) && Stb_slave_i_lbus;
   assign in_win_s = (Adr_slave_i_lbus[15:3] == BASE_ADDR[15:3]);
   assign offset_s = Adr_slave_i_lbus[2:0];
   assign wr_en_s  = accept_s && We_slave_i_lbus && in_win_s;

   // Bus FSM state register
   always_ff @(posedge CLK_32 or posedge RESET_MKO) begin
      if (RESET_MKO) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Bus FSM next state: one access per strobe, wait for release before re-arming
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Stb_slave_i_lbus) state_s = ST_ACK;
            else                  state_s = ST_IDLE;
         end
         ST_ACK:  state_s = ST_WAIT_REL;
         ST_WAIT_REL: begin
            if (Stb_slave_i_lbus) state_s = ST_WAIT_REL;
            else                  state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Bus FSM outputs: ack and read-data drive enable
   always_comb begin
      ack_s   = 1'b0;
      drive_s = 1'b0;
      if (state_r == ST_ACK) begin
         ack_s   = 1'b1;
         drive_s = ~We_slave_i_lbus;
      end else begin
         ack_s   = 1'b0;
         drive_s = 1'b0;
      end
   end

   assign Ack_slave_o_lbus  = ack_s;
   assign Dat_slave_io_lbus = drive_s ? rd_data_r : 16'hzzzz;

   // Configuration registers and start pulse, updated on the accepting edge
   always_ff @(posedge CLK_32 or posedge RESET_MKO) begin
      if (RESET_MKO) begin
         ctrl_r    <= 16'h0000;
         txdata_r  <= 16'h0000;
         cmd_r     <= 16'h0000;
         subaddr_r <= 16'h0000;
         chan_r    <= 5'h00;
         start_r   <= 1'b0;
      end else begin
         start_r <= wr_en_s && (offset_s == 3'd4);
         if (wr_en_s) begin
            case (offset_s)
               3'd0:    ctrl_r    <= Dat_slave_io_lbus;
               3'd1:    txdata_r  <= Dat_slave_io_lbus;
               3'd2:    cmd_r     <= Dat_slave_io_lbus;
               3'd3:    subaddr_r <= Dat_slave_io_lbus;
               3'd4:    chan_r    <= Dat_slave_io_lbus[4:0];
               default: ;
            endcase
         end
      end
   end

   // Two-flop synchronizer for the asynchronous ready inputs; idles at "not ready"
   always_ff @(posedge CLK_32 or posedge RESET_MKO) begin
      if (RESET_MKO) begin
         sync1_r <= 5'h1F;
         sync2_r <= 5'h1F;
      end else begin
         sync1_r <= MKO_READYD_N;
         sync2_r <= sync1_r;
      end
   end

`ifdef UVV_MKO_READBACK_EN
   // Read mux with full readback of the configuration registers
   always_comb begin
      rd_mux_s = 16'h0000;
      if (in_win_s) begin
         case (offset_s)
            3'd0:    rd_mux_s = ctrl_r;
            3'd1:    rd_mux_s = txdata_r;
            3'd2:    rd_mux_s = cmd_r;
            3'd3:    rd_mux_s = subaddr_r;
            3'd4:    rd_mux_s = {11'h000, chan_r};
            3'd5:    rd_mux_s = {11'h000, ~sync2_r};
            default: rd_mux_s = 16'h0000;
         endcase
      end else begin
         rd_mux_s = 16'h0000;
      end
   end
`else
   // Bits 14:1 of CTRL have no consumer when configuration is write-only
   logic ctrl_unused_s;
   assign ctrl_unused_s = ^ctrl_r[14:1];

   // Read mux: configuration registers are write-only, only STATUS reads back
   always_comb begin
      rd_mux_s = 16'h0000;
      if (in_win_s && (offset_s == 3'd5)) begin
         rd_mux_s = {11'h000, ~sync2_r};
      end else begin
         rd_mux_s = 16'h0000;
      end
   end
`endif

   // Read data captured on the accepting edge so the bus value is stable for the whole ack
   always_ff @(posedge CLK_32 or posedge RESET_MKO) begin
      if (RESET_MKO) begin
         rd_data_r <= 16'h0000;
      end else if (accept_s && !We_slave_i_lbus) begin
         rd_data_r <= rd_mux_s;
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   assign MKO_RESET_N = ctrl_r[0];
   assign MKO_BUS_SEL = ctrl_r[15];
   assign MKO_DATA    = txdata_r;
   assign MKO_CMD     = cmd_r;
   assign MKO_SA      = subaddr_r;
   assign MKO_CHAN_EN = chan_r;
   assign MKO_START   = start_r;

endmodule

// File: tb/tb_uvv_mko_top.sv
// Self-checking bench for uvv_mko_top: directed bus accesses plus a randomized run against an address-map model.
module tb_uvv_mko_top;

`ifdef UVV_MKO_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stb;
   logic        we;
   logic [15:0] adr;
   logic [15:0] tb_dat;
   logic        tb_drive;
   tri0  [15:0] dat_bus;
   logic        ack;
   logic [4:0]  readyd_n;
   logic        mko_reset_n;
   logic        mko_bus_sel;
   logic [15:0] mko_data;
   logic [15:0] mko_cmd;
   logic [15:0] mko_sa;
   logic [4:0]  mko_chan_en;
   logic        mko_start;

   int n_cmp = 0;
   int n_err = 0;

   // Model: stored value per window offset 0..4
   logic [15:0] m_reg [0:4];

   assign dat_bus = tb_drive ? tb_dat : 16'hzzzz;

   always #16 clk = ~clk;

   uvv_mko_top dut (
      .CLK_32            (clk),
      .RESET_MKO         (rst),
      .Adr_slave_i_lbus  (adr),
      .Dat_slave_io_lbus (dat_bus),
      .We_slave_i_lbus   (we),
      .Stb_slave_i_lbus  (stb),
      .Ack_slave_o_lbus  (ack),
      .MKO_READYD_N      (readyd_n),
      .MKO_RESET_N       (mko_reset_n),
      .MKO_BUS_SEL       (mko_bus_sel),
      .MKO_DATA          (mko_data),
      .MKO_CMD           (mko_cmd),
      .MKO_SA            (mko_sa),
      .MKO_CHAN_EN       (mko_chan_en),
      .MKO_START         (mko_start)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_window(input logic [15:0] a);
      return (a >= 16'hA000) && (a <= 16'hA007);
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      int off;
      if (!in_window(a)) return 16'h0000;
      off = int'(a - 16'hA000);
      if (off == 5) return {11'h000, ~readyd_n};
      if (off <= 4 && READBACK) return m_reg[off];
      return 16'h0000;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [15:0] d);
      int off;
      if (in_window(a)) begin
         off = int'(a - 16'hA000);
         if (off == 4) m_reg[4] = d & 16'h001F;
         else if (off < 4) m_reg[off] = d;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_reg[i] = 16'h0000;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".reset_n"}, {31'd0, mko_reset_n}, {31'd0, m_reg[0][0]});
      chk({tag, ".bus_sel"}, {31'd0, mko_bus_sel}, {31'd0, m_reg[0][15]});
      chk({tag, ".data"},    {16'd0, mko_data},    {16'd0, m_reg[1]});
      chk({tag, ".cmd"},     {16'd0, mko_cmd},     {16'd0, m_reg[2]});
      chk({tag, ".sa"},      {16'd0, mko_sa},      {16'd0, m_reg[3]});
      chk({tag, ".chan"},    {27'd0, mko_chan_en}, {27'd0, m_reg[4][4:0]});
   endtask

   // One complete bus access; strobe held 'hold' extra cycles after ack
   task automatic access(input string tag, input logic [15:0] a, input bit w,
                         input logic [15:0] d, input int hold);
      int acks;
      int starts;
      bit got;
      logic [15:0] rd;
      logic [15:0] exp_rd;
      acks = 0; starts = 0; got = 1'b0; rd = 16'h0000;
      exp_rd = model_read(a);
      @(negedge clk);
      adr = a; we = w; tb_dat = d; tb_drive = w; stb = 1'b1;
      for (int c = 0; c < 8 && !got; c++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin
            got = 1'b1; acks++;
            rd = dat_bus;
            if (mko_start === 1'b1) starts++;
         end
      end
      chk({tag, ".ack_seen"}, {31'd0, got}, 32'd1);
      if (w) model_write(a, d);
      else   chk({tag, ".rdata"}, {16'd0, rd}, {16'd0, exp_rd});
      for (int c = 0; c <= hold; c++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) acks++;
         if (mko_start === 1'b1) starts++;
      end
      @(negedge clk);
      stb = 1'b0; tb_drive = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) acks++;
         if (mko_start === 1'b1) starts++;
      end
      chk({tag, ".ack_count"}, acks, 32'd1);
      chk({tag, ".start_count"}, starts, {31'd0, (w && a == 16'hA004)});
      chk({tag, ".bus_released"}, {16'd0, dat_bus}, 32'd0);
      check_outputs(tag);
   endtask

   initial begin
      logic [15:0] a;
      bit          got;
      rst = 1'b1; stb = 1'b0; we = 1'b0; adr = 16'h0000; tb_dat = 16'h0000;
      tb_drive = 1'b0; readyd_n = 5'h1F;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ack", {31'd0, ack}, 32'd0);
      chk("rst.start", {31'd0, mko_start}, 32'd0);
      chk("rst.bus", {16'd0, dat_bus}, 32'd0);
      check_outputs("rst");
      @(negedge clk);
      rst = 1'b0;

      // Control register and bus select
      access("w_ctrl1", 16'hA000, 1'b1, 16'h0001, 0);
      chk("w_ctrl1.reset_n_const", {31'd0, mko_reset_n}, 32'd1);
      access("w_ctrl2", 16'hA000, 1'b1, 16'h8001, 0);
      chk("w_ctrl2.bus_sel_const", {31'd0, mko_bus_sel}, 32'd1);

      // Data, subaddress, command, channel
      access("w_tx", 16'hA001, 1'b1, 16'h0002, 0);
      access("w_sa", 16'hA003, 1'b1, 16'h0003, 0);
      access("w_cmd", 16'hA002, 1'b1, 16'h0003, 0);
      access("w_chan", 16'hA004, 1'b1, 16'h0003, 0);
      chk("w_chan.const", {27'd0, mko_chan_en}, 32'h03);

      // Strobe held long after ack: still one access, one start
      access("hold_chan", 16'hA004, 1'b1, 16'hFFF5, 5);

      // Strobe pulse that never meets a rising edge: no access
      @(negedge clk);
      adr = 16'hA004; we = 1'b1; tb_dat = 16'h0001; tb_drive = 1'b1;
      #4 stb = 1'b1;
      #4 stb = 1'b0; tb_drive = 1'b0;
      got = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack === 1'b1 || mko_start === 1'b1) got = 1'b1;
      end
      chk("short_stb.no_ack", {31'd0, got}, 32'd0);
      check_outputs("short_stb");

      // Status through the synchronizer
      readyd_n = 5'b11111;
      repeat (4) @(posedge clk);
      access("r_stat0", 16'hA005, 1'b0, 16'h0000, 0);
      @(negedge clk);
      readyd_n = 5'b10110;
      repeat (3) @(posedge clk);
      access("r_stat1", 16'hA005, 1'b0, 16'h0000, 0);
      access("w_stat_ign", 16'hA005, 1'b1, 16'hFFFF, 0);

      // Readback, reserved and out-of-window
      access("w_tx2", 16'hA001, 1'b1, 16'h8002, 0);
      access("r_tx2", 16'hA001, 1'b0, 16'h0000, 1);
      access("w_resv", 16'hA006, 1'b1, 16'h5A5A, 0);
      access("r_resv", 16'hA007, 1'b0, 16'h0000, 0);
      access("w_oow", 16'h1234, 1'b1, 16'hDEAD, 0);
      access("r_oow", 16'h1234, 1'b0, 16'h0000, 0);

      // Randomized accesses
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            readyd_n = 5'($urandom);
            repeat (3) @(posedge clk);
         end
         if ($urandom_range(0, 3) != 0) a = 16'hA000 + 16'($urandom_range(0, 7));
         else                           a = 16'($urandom);
         access("rand", a, 1'($urandom), 16'($urandom), $urandom_range(0, 3));
      end

      // Reset asserted in the middle of an ack cycle, strobe kept high
      @(negedge clk);
      adr = 16'hA001; we = 1'b1; tb_dat = 16'hBEEF; tb_drive = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid.ack_before", {31'd0, ack}, 32'd1);
      model_write(16'hA001, 16'hBEEF);
      check_outputs("rst_mid.pre");
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_mid.ack_drop", {31'd0, ack}, 32'd0);
      check_outputs("rst_mid.post");
      @(negedge clk);
      rst = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) got = 1'b1;
      end
      chk("rst_mid.new_access", {31'd0, got}, 32'd1);
      model_write(16'hA001, 16'hBEEF);
      @(negedge clk);
      stb = 1'b0; tb_drive = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("rst_mid.after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
